// File: rtl/imager_frame_rx.sv
// Imager pixel-stream receiver: tracks frame position, writes pixels into a frame RAM,
// accumulates a per-frame checksum and flags frame completion and protocol errors.
module imager_frame_rx #(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 12,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [7:0]        pix_data,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic              pix_eol,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_sum,
    output logic              frame_err,
    output logic              line_err
);

    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    state_t              state_r, state_s;
    logic [CW-1:0]       col_r, col_s;
    logic [RW-1:0]       row_r, row_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [15:0]         acc_r, acc_s;

    logic                wr_en_r, wr_en_s;
    logic [ADDR_W-1:0]   wr_addr_r, wr_addr_s;
    logic [7:0]          wr_data_r, wr_data_s;
    logic                busy_r, busy_s;
    logic                frame_done_r, frame_done_s;
    logic [15:0]         frame_sum_r, frame_sum_s;
    logic                frame_err_r, frame_err_s;
    logic                line_err_r, line_err_s;

    logic                accept_sof_s;
    logic                accept_pix_s;
    logic                at_eol_s;
    logic                at_last_s;
    logic [15:0]         acc_add_s;

    // A SOF is taken in IDLE only when enabled; in CAPTURE it always restarts the frame.
    assign accept_sof_s = pix_valid && pix_sof && ((state_r == CAPTURE) || enable);
    assign accept_pix_s = pix_valid && !pix_sof && (state_r == CAPTURE);
    assign at_eol_s     = (col_r == COL_LAST);
    assign at_last_s    = at_eol_s && (row_r == ROW_LAST);
    assign acc_add_s    = acc_r + {8'h00, pix_data};

    // Next-state, position counters and registered output values.
    always_comb begin
        state_s      = state_r;
        col_s        = col_r;
        row_s        = row_r;
        addr_s       = addr_r;
        acc_s        = acc_r;
        wr_en_s      = 1'b0;
        wr_addr_s    = wr_addr_r;
        wr_data_s    = wr_data_r;
        frame_done_s = 1'b0;
        frame_sum_s  = frame_sum_r;
        frame_err_s  = 1'b0;
        line_err_s   = line_err_r;

        if (accept_sof_s) begin
            state_s     = CAPTURE;
            col_s       = CW'(1);
            row_s       = {RW{1'b0}};
            addr_s      = ADDR_W'(1);
            acc_s       = {8'h00, pix_data};
            wr_en_s     = 1'b1;
            wr_addr_s   = {ADDR_W{1'b0}};
            wr_data_s   = pix_data;
            frame_err_s = (state_r == CAPTURE);
            // SOF pixel sits at column 0, which is never the end of a line.
            line_err_s  = pix_eol;
        end else if (accept_pix_s) begin
            wr_en_s     = 1'b1;
            wr_addr_s   = addr_r;
            wr_data_s   = pix_data;
            acc_s       = acc_add_s;
            line_err_s  = line_err_r || (pix_eol != at_eol_s);
            if (at_last_s) begin
                state_s      = IDLE;
                col_s        = {CW{1'b0}};
                row_s        = {RW{1'b0}};
                addr_s       = {ADDR_W{1'b0}};
                frame_done_s = 1'b1;
                frame_sum_s  = acc_add_s;
            end else if (at_eol_s) begin
                col_s  = {CW{1'b0}};
                row_s  = row_r + RW'(1);
                addr_s = addr_r + ADDR_W'(1);
            end else begin
                col_s  = col_r + CW'(1);
                addr_s = addr_r + ADDR_W'(1);
            end
        end else begin
            state_s = state_r;
        end

        if (state_s == CAPTURE) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            col_r        <= {CW{1'b0}};
            row_r        <= {RW{1'b0}};
            addr_r       <= {ADDR_W{1'b0}};
            acc_r        <= 16'h0000;
            wr_en_r      <= 1'b0;
            wr_addr_r    <= {ADDR_W{1'b0}};
            wr_data_r    <= 8'h00;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            frame_sum_r  <= 16'h0000;
            frame_err_r  <= 1'b0;
            line_err_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            col_r        <= col_s;
            row_r        <= row_s;
            addr_r       <= addr_s;
            acc_r        <= acc_s;
            wr_en_r      <= wr_en_s;
            wr_addr_r    <= wr_addr_s;
            wr_data_r    <= wr_data_s;
            busy_r       <= busy_s;
            frame_done_r <= frame_done_s;
            frame_sum_r  <= frame_sum_s;
            frame_err_r  <= frame_err_s;
            line_err_r   <= line_err_s;
        end
    end

    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign frame_sum  = frame_sum_r;
    assign frame_err  = frame_err_r;
    assign line_err   = line_err_r;

endmodule

// File: tb/tb_imager_frame_rx.sv
// Table-driven bench for imager_frame_rx (4x3 frame): each record holds one cycle of
// stimulus and the outputs expected right after the clock edge that consumes it.
module tb_imager_frame_rx;

    logic        clk = 1'b0;
    logic        reset, enable, pix_valid, pix_sof, pix_eol;
    logic [7:0]  pix_data;
    logic        wr_en, busy, frame_done, frame_err, line_err;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] frame_sum;

    int checks = 0;
    int errors = 0;
    logic done = 1'b0;

    typedef struct {
        logic        rst, v, s, e, en;
        logic [7:0]  d;
        logic        we;
        logic [3:0]  a;
        logic [7:0]  wd;
        logic        b, fd;
        logic [15:0] fs;
        logic        fe, le;
    } vec_t;

    vec_t vecs[$];

    // Expected values of outputs that hold between events.
    logic [3:0]  h_addr;
    logic [7:0]  h_data;
    logic [15:0] h_sum;

    imager_frame_rx #(.WIDTH(4), .HEIGHT(3), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eol(pix_eol),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .frame_done(frame_done), .frame_sum(frame_sum), .frame_err(frame_err),
        .line_err(line_err)
    );

    always #5 clk = ~clk;

    // Watchdog: the run must complete within a bounded time.
    initial begin
        #100000;
        if (!done) begin
            errors++;
            $display("FAIL timeout: vector replay did not finish in time");
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic add(input logic rst, input logic v, input logic s, input logic e,
                       input logic en, input logic [7:0] d, input logic we,
                       input logic [3:0] a, input logic b, input logic fd,
                       input logic [15:0] fs, input logic fe, input logic le);
        vec_t t;
        if (rst) begin
            h_addr = 4'd0;
            h_data = 8'd0;
            h_sum  = 16'd0;
        end
        if (we) begin
            h_addr = a;
            h_data = d;
        end
        if (fd) h_sum = fs;
        t.rst = rst; t.v = v; t.s = s; t.e = e; t.en = en; t.d = d;
        t.we = we; t.a = h_addr; t.wd = h_data; t.b = b; t.fd = fd;
        t.fs = h_sum; t.fe = fe; t.le = le;
        vecs.push_back(t);
    endtask

    // Idle cycle with noisy markers that must be ignored because pix_valid is low.
    task automatic gap(input logic b, input logic le);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hAA, 1'b0, 4'd0, b, 1'b0, 16'd0, 1'b0, le);
    endtask

    initial begin
        logic [32:0] act, exp;

        h_addr = 4'd0; h_data = 8'd0; h_sum = 16'd0;

        // Reset state
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);

        // Clean frame 1..12, sum 78
        for (int i = 1; i <= 12; i++)
            add(1'b0, 1'b1, i == 1, (i % 4) == 0, 1'b1, 8'(i), 1'b1, 4'(i - 1),
                i != 12, i == 12, 16'd78, 1'b0, 1'b0);
        gap(1'b0, 1'b0);

        // Gapped frame: same data, alternate idle cycles
        for (int i = 1; i <= 12; i++) begin
            add(1'b0, 1'b1, i == 1, (i % 4) == 0, 1'b1, 8'(i), 1'b1, 4'(i - 1),
                i != 12, i == 12, 16'd78, 1'b0, 1'b0);
            gap(i != 12, 1'b0);
        end

        // Early SOF: 6 pixels, then restart with 9 followed by eleven 2s -> sum 31
        for (int j = 0; j < 6; j++)
            add(1'b0, 1'b1, j == 0, j == 3, 1'b1, 8'(j + 1), 1'b1, 4'(j),
                1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd9, 1'b1, 4'd0, 1'b1, 1'b0, 16'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 11; k++)
            add(1'b0, 1'b1, 1'b0, (k % 4) == 3, 1'b1, 8'd2, 1'b1, 4'(k),
                k != 11, k == 11, 16'd31, 1'b0, 1'b0);
        gap(1'b0, 1'b0);

        // Line error: EOL on pixel 3 instead of 4, sticky through frame_done
        for (int i = 1; i <= 12; i++)
            add(1'b0, 1'b1, i == 1, (i == 3) || (i == 8) || (i == 12), 1'b1, 8'(i), 1'b1,
                4'(i - 1), i != 12, i == 12, 16'd78, 1'b0, i >= 3);
        gap(1'b0, 1'b1);

        // Idle filter: non-SOF pixel in IDLE, then SOF with enable low
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd5, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd6, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1);

        // Back-to-back frames; enable dropped during the second one. Sums 78 and 90.
        for (int i = 1; i <= 12; i++)
            add(1'b0, 1'b1, i == 1, (i % 4) == 0, 1'b1, 8'(i), 1'b1, 4'(i - 1),
                i != 12, i == 12, 16'd78, 1'b0, 1'b0);
        for (int i = 1; i <= 12; i++)
            add(1'b0, 1'b1, i == 1, (i % 4) == 0, i == 1, 8'(i + 1), 1'b1, 4'(i - 1),
                i != 12, i == 12, 16'd90, 1'b0, 1'b0);
        gap(1'b0, 1'b0);

        // Reset after 6 pixels, then a fresh frame of twelve 10s -> sum 120
        for (int j = 0; j < 6; j++)
            add(1'b0, 1'b1, j == 0, j == 3, 1'b1, 8'(j + 1), 1'b1, 4'(j),
                1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd7, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        gap(1'b0, 1'b0);
        for (int i = 1; i <= 12; i++)
            add(1'b0, 1'b1, i == 1, (i % 4) == 0, 1'b1, 8'd10, 1'b1, 4'(i - 1),
                i != 12, i == 12, 16'd120, 1'b0, 1'b0);
        gap(1'b0, 1'b0);

        reset = 1'b1; enable = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
        pix_eol = 1'b0; pix_data = 8'h00;

        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if ({wr_en, wr_addr, wr_data, busy, frame_done, frame_sum, frame_err, line_err}
            !== 33'd0) begin
            errors++;
            $display("FAIL reset state: we=%b addr=%0d data=%0d busy=%b done=%b sum=%0d ferr=%b lerr=%b",
                     wr_en, wr_addr, wr_data, busy, frame_done, frame_sum, frame_err, line_err);
        end

        foreach (vecs[n]) begin
            @(negedge clk);
            reset     = vecs[n].rst;
            pix_valid = vecs[n].v;
            pix_sof   = vecs[n].s;
            pix_eol   = vecs[n].e;
            enable    = vecs[n].en;
            pix_data  = vecs[n].d;
            @(posedge clk);
            #1;
            act = {wr_en, wr_addr, wr_data, busy, frame_done, frame_sum, frame_err, line_err};
            exp = {vecs[n].we, vecs[n].a, vecs[n].wd, vecs[n].b, vecs[n].fd,
                   vecs[n].fs, vecs[n].fe, vecs[n].le};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL vec%0d: got we=%b addr=%0d data=%0d busy=%b done=%b sum=%0d ferr=%b lerr=%b, want we=%b addr=%0d data=%0d busy=%b done=%b sum=%0d ferr=%b lerr=%b",
                         n, wr_en, wr_addr, wr_data, busy, frame_done, frame_sum, frame_err,
                         line_err, exp[32], exp[31:28], exp[27:20], exp[19], exp[18],
                         exp[17:2], exp[1], exp[0]);
            end
        end

        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
